// File: rtl/jtsdram_bank_pkg.sv
// Shared types for the SDRAM bank exerciser.
// FSM encoding, phase encoding and the address-derived test pattern.
package jtsdram_bank_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_RDY,
      GAP,
      DONE
   } state_t;

   typedef enum logic {
      PH_WR = 1'b0,
      PH_RD = 1'b1
   } phase_t;

   localparam int PAT_MAXW = 64;

   // Callers zero-extend both operands and truncate the result to DW
   function automatic logic [PAT_MAXW-1:0] pat(
      input logic [PAT_MAXW-1:0] seed,
      input logic [PAT_MAXW-1:0] a
   );
      return seed ^ a;
   endfunction

endpackage

// File: rtl/jtsdram_rnd.sv
// Free-running 16-bit maximal-length LFSR (taps 16,14,13,11).
// The low W bits are exported as a pseudo-random value.
module jtsdram_rnd #(
   parameter int W = 16
) (
   input  logic         rst,
   input  logic         clk,
   output logic [W-1:0] rnd
);

   logic [15:0] r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r <= 16'hACE1;
      else     r <= {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
   end

   assign rnd = r[W-1:0];

endmodule

// File: rtl/jtsdram_bank_rw.sv
// SDRAM bank exerciser: optional write fill, then read-back verify.
// Counts mismatches and keeps the address of the first one.
module jtsdram_bank_rw
   import jtsdram_bank_pkg::*;
#(
   parameter int AW   = 22,
   parameter int DW   = 16,
   parameter int GAPW = 4,
   parameter int ERRW = 8
) (
   input  logic            rst,
   input  logic            clk,
   input  logic            LVBL,
   input  logic            start,
   input  logic            wr_en,
   input  logic            slow,
   input  logic [DW-1:0]   seed,
   output logic [AW-1:0]   sdram_addr,
   output logic            sdram_rd,
   output logic            sdram_wr,
   output logic [DW-1:0]   sdram_din,
   input  logic            ack,
   input  logic            rdy,
   input  logic [DW-1:0]   data_read,
   output logic [AW-1:0]   cnt_addr,
   output logic            busy,
   output logic            done,
   output logic            bad,
   output logic [ERRW-1:0] err_cnt,
   output logic [AW-1:0]   first_bad
);

   state_t          state, state_nx;
   phase_t          ph;
   logic [DW-1:0]   seed_q, pend_seed, new_seed, pat_w;
   logic            pend_wr, new_wr, start_pend;
   logic [GAPW-1:0] gap, lfsr;
   logic            restart, complete, last, req;

   jtsdram_rnd #(.W(GAPW)) u_rnd (
      .rst (rst),
      .clk (clk),
      .rnd (lfsr)
   );

   assign pat_w    = DW'(pat(PAT_MAXW'(seed_q), PAT_MAXW'(cnt_addr)));
   assign last     = &cnt_addr;
   assign req      = (state == ISSUE) || (state == WAIT_ACK);
   assign new_seed = start ? seed  : pend_seed;
   assign new_wr   = start ? wr_en : pend_wr;

   assign sdram_addr = cnt_addr;
   assign sdram_rd   = req && (ph == PH_RD);
   assign sdram_wr   = req && (ph == PH_WR);
   assign sdram_din  = sdram_wr ? pat_w : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      restart  = 1'b0;
      complete = 1'b0;
      unique case (state)
         IDLE, DONE: restart = start;
         ISSUE: begin
            if (start) restart  = 1'b1;
            else       state_nx = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack && rdy) complete = 1'b1;
            else if (ack)   state_nx = WAIT_RDY;
         end
         WAIT_RDY: complete = rdy;
         GAP: begin
            if (start)
               restart = 1'b1;
            else if (gap == '0 && (slow || LVBL))
               state_nx = ISSUE;
         end
         default: state_nx = IDLE;
      endcase
      // A pending restart waits for the in-flight transaction to finish
      if (complete) begin
         if (start || start_pend)        restart  = 1'b1;
         else if (last && ph == PH_RD)   state_nx = DONE;
         else                            state_nx = GAP;
      end
      if (restart) state_nx = ISSUE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph         <= PH_WR;
         seed_q     <= '0;
         pend_seed  <= '0;
         pend_wr    <= 1'b0;
         start_pend <= 1'b0;
         gap        <= '0;
         cnt_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bad        <= 1'b0;
         err_cnt    <= '0;
         first_bad  <= '0;
      end else if (restart) begin
         seed_q     <= new_seed;
         ph         <= new_wr ? PH_WR : PH_RD;
         start_pend <= 1'b0;
         gap        <= '0;
         cnt_addr   <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
         bad        <= 1'b0;
         err_cnt    <= '0;
         first_bad  <= '0;
      end else begin
         if (start && (state == WAIT_ACK || state == WAIT_RDY)) begin
            start_pend <= 1'b1;
            pend_seed  <= seed;
            pend_wr    <= wr_en;
         end
         if (state == GAP && gap != '0)
            gap <= gap - GAPW'(1);
         if (complete) begin
            if (ph == PH_RD && data_read != pat_w) begin
               bad <= 1'b1;
               if (err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
               if (err_cnt == '0) first_bad <= cnt_addr;
            end
            gap <= slow ? lfsr : '0;
            if (last) begin
               cnt_addr <= '0;
               if (ph == PH_WR) begin
                  ph <= PH_RD;
               end else begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end else begin
               cnt_addr <= cnt_addr + AW'(1);
            end
         end
      end
   end

endmodule

// File: doc/jtsdram_bank_rw.md
Name: jtsdram_bank_rw

Overview:
Parametrised SDRAM bank exerciser.
- Optionally fills a whole bank with an address-derived pattern, then reads the bank back and verifies every word.
- Sits between the test controller and one bank port of the SDRAM controller, one instance per bank.
- Adds over the read-only checker: a write phase, configurable address/data width, an error counter and capture of the first failing address.

Parameters:
AW, 22, address width in words; bank size is 2^AW.
DW, 16, data word width.
GAPW, 4, width of the random inter-request gap counter (slow mode).
ERRW, 8, width of the saturating error counter.

Ports:
rst  in  1  asynchronous active-high reset
clk  in  1  clock
LVBL  in  1  vertical blank, active low; gates requests in fast mode
start  in  1  one-cycle pulse, starts a test run
wr_en  in  1  sampled at start; 1 = write phase before read phase
slow  in  1  1 = random gaps between requests; 0 = requests only while LVBL=1
seed  in  DW  pattern seed, sampled at start
sdram_addr  out  AW  request address
sdram_rd  out  1  read request
sdram_wr  out  1  write request
sdram_din  out  DW  write data
ack  in  1  controller accepted the request
rdy  in  1  transaction complete; read data valid
data_read  in  DW  read data
cnt_addr  out  AW  current address
busy  out  1  run in progress
done  out  1  sticky; run finished
bad  out  1  sticky; at least one mismatch
err_cnt  out  ERRW  mismatches, saturating at all-ones
first_bad  out  AW  address of the first mismatch

Behaviour:
- Reset: all outputs 0; FSM=IDLE; seed register 0.
- Interface: reset is rst, asynchronous, active-high; clock is clk. Everything is synchronous to clk.
- Pattern: pat(a) = seed_q XOR a, with a zero-extended or truncated to DW. Bits DW-1:AW are 0 when AW<DW.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_RDY, GAP, DONE. A phase bit ph selects WR or RD.
- start, from IDLE or DONE:
  - latch seed_q, ph = wr_en ? WR : RD
  - clear cnt_addr, done, bad, err_cnt, first_bad
  - busy=1, go to ISSUE on the next cycle.
- start during WAIT_ACK or WAIT_RDY: set start_pend. It is honoured when the outstanding transaction reaches rdy, with the same actions as above. The controller handshake is never abandoned. start in ISSUE or GAP restarts immediately.
- ISSUE:
  - sdram_addr = cnt_addr, set in the same cycle.
  - ph=WR: sdram_wr=1 with sdram_din = pat(cnt_addr).
  - ph=RD: sdram_rd=1.
  - Go to WAIT_ACK.
- WAIT_ACK: hold request, address and data stable until ack=1. On ack, drop the request the next cycle and go to WAIT_RDY. ack and rdy in the same cycle counts as both; go straight to completion.
- WAIT_RDY: on rdy, complete the transaction.
  - ph=RD: compare data_read against pat(cnt_addr). On mismatch: bad=1; err_cnt += 1 unless saturated; first_bad = cnt_addr if err_cnt was 0.
  - rdy outside WAIT_RDY/WAIT_ACK is ignored.
- Completion when cnt_addr is all-ones:
  - ph=WR: ph=RD, cnt_addr=0, continue.
  - ph=RD: go to DONE; done=1, busy=0.
- Completion otherwise: cnt_addr += 1 (wraps modulo 2^AW only at phase end). Then:
  - slow=1: load gap counter with lfsr[GAPW-1:0] and enter GAP. The LFSR advances every cycle.
  - slow=0: enter GAP with gap counter 0.
- GAP:
  - slow=1: decrement to 0, then go to ISSUE.
  - slow=0: go to ISSUE as soon as gap counter is 0 and LVBL=1.
  - slow is re-sampled every cycle in GAP.
- Latency: with an immediate ack and rdy one cycle later, one transaction takes 4 cycles (ISSUE, WAIT_ACK, WAIT_RDY, GAP).
- sdram_rd and sdram_wr are never high together. Neither is high outside ISSUE/WAIT_ACK.

Decomposition:
- Package jtsdram_bank_pkg: FSM state encoding, phase encoding, pattern function pat().
- Sub-module: reuse the existing jtsdram_rnd LFSR for gap generation. No other sub-modules.

Test Plan:
(All with AW=4, DW=16, zero-latency model: ack 1 cycle after request, rdy 2 cycles after.)
- wr_en=1, seed=16'hA5A5, slow=0, LVBL=1 -> 16 writes with din = A5A5^addr, then 16 reads; done=1, bad=0, err_cnt=0, busy low after the last rdy.
- Same run, model corrupts the read at addr 5 and addr 9 -> bad=1, err_cnt=2, first_bad=5.
- wr_en=0, model returns 0 everywhere, ERRW=2 -> err_cnt saturates at 3, first_bad=0, done=1.
- slow=0, LVBL=0 held for 50 cycles mid-run -> no sdram_rd/sdram_wr during the hold; resumes on LVBL=1; final result unchanged.
- start pulse while in WAIT_RDY at addr 7 -> request stays until rdy; next request is addr 0 with the new seed; err_cnt cleared.
- slow=1 -> gaps between requests vary, each ≤ 2^GAPW-1 cycles plus one; all 32 transactions complete; rd and wr never overlap (assertion).
